// File: rtl/pipe_stage_skid_reg_if.sv
// rtl/pipe_stage_skid_reg_if.sv - upstream/downstream handshake bundle for the skid pipeline stage
interface pipe_stage_skid_reg_if #(
   parameter int DATA_W = 64
);
   logic              IN_VALID;
   logic [DATA_W-1:0] IN_DATA;
   logic              IN_READY;
   logic              OUT_VALID;
   logic [DATA_W-1:0] OUT_DATA;
   logic              OUT_READY;

   // The stage itself: consumes upstream payload, produces downstream payload.
   modport slave (
      input  IN_VALID, IN_DATA, OUT_READY,
      output IN_READY, OUT_VALID, OUT_DATA
   );

   // Whatever surrounds the stage: drives upstream payload and downstream ready.
   modport master (
      output IN_VALID, IN_DATA, OUT_READY,
      input  IN_READY, OUT_VALID, OUT_DATA
   );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - two-entry skid pipeline register with flush and stall counter
module pipe_stage_skid_reg #(
   parameter int                DATA_W      = 64,
   parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
   parameter int                CNT_W       = 16
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  FLUSH,
   pipe_stage_skid_reg_if.slave  stream,
   output logic [1:0]            OCCUPANCY,
   output logic [CNT_W-1:0]      STALL_CNT
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] main_q, main_nxt;
   logic [DATA_W-1:0] skid_q, skid_nxt;
   logic [CNT_W-1:0]  stall_q;
   logic              in_ready, out_valid;
   logic              in_fire, out_fire;

   // Ready and valid depend only on registered state, so ready never
   // combinationally follows downstream ready, upstream valid or flush.
   assign in_ready  = (state != S_FULL);
   assign out_valid = (state != S_EMPTY);
   assign in_fire   = stream.IN_VALID & in_ready;
   assign out_fire  = out_valid & stream.OUT_READY;

   assign stream.IN_READY  = in_ready;
   assign stream.OUT_VALID = out_valid;
   assign stream.OUT_DATA  = out_valid ? main_q : BUBBLE_DATA;
   assign OCCUPANCY        = state;
   assign STALL_CNT        = stall_q;

   // State register plus MAIN/SKID storage; reset discards everything at once.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state  <= S_EMPTY;
         main_q <= BUBBLE_DATA;
         skid_q <= BUBBLE_DATA;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
         skid_q <= skid_nxt;
      end
   end

   // Next-state and data movement; a flush overrides any fire in the same cycle.
   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      case (state)
         S_EMPTY: begin
            if (in_fire) begin
               main_nxt  = stream.IN_DATA;
               state_nxt = S_ONE;
            end
         end
         S_ONE: begin
            if (in_fire && out_fire) begin
               main_nxt = stream.IN_DATA;
            end else if (in_fire) begin
               skid_nxt  = stream.IN_DATA;
               state_nxt = S_FULL;
            end else if (out_fire) begin
               state_nxt = S_EMPTY;
            end
         end
         S_FULL: begin
            if (out_fire) begin
               main_nxt  = skid_q;
               state_nxt = S_ONE;
            end
         end
         default: state_nxt = S_EMPTY;
      endcase
      if (FLUSH) begin
         state_nxt = S_EMPTY;
         main_nxt  = BUBBLE_DATA;
         skid_nxt  = BUBBLE_DATA;
      end
   end

   // Saturating count of edges where downstream holds off a valid entry; flush leaves it alone.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stall_q <= '0;
      end else if (out_valid && !stream.OUT_READY && (stall_q != {CNT_W{1'b1}})) begin
         stall_q <= stall_q + 1'b1;
      end
   end

endmodule

// File: doc/pipe_stage_skid_reg.md
PIPE_STAGE_SKID_REG -- requirements
Module: pipe_stage_skid_reg

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the payload width (instruction plus PC+4 for IF/ID use).
REQ-002 Parameter BUBBLE_DATA, default 0 (DATA_W bits), SHALL be the payload value presented whenever the stage holds no valid entry.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall-cycle counter width.
REQ-004 CLK  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-005 RESET  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 FLUSH  input  1  SHALL be the synchronous kill of all held entries (branch or jump redirect).
REQ-007 IN_VALID  input  1  SHALL mark IN_DATA as valid from the upstream stage.
REQ-008 IN_DATA  input  DATA_W  SHALL be the upstream payload.
REQ-009 IN_READY  output  1  SHALL indicate that the stage accepts an entry this cycle.
REQ-010 OUT_VALID  output  1  SHALL mark OUT_DATA as valid to the downstream stage.
REQ-011 OUT_DATA  output  DATA_W  SHALL be the downstream payload.
REQ-012 OUT_READY  input  1  SHALL indicate that the downstream stage consumes OUT_DATA this cycle.
REQ-013 OCCUPANCY  output  2  SHALL report the held-entry count (0, 1 or 2).
REQ-014 STALL_CNT  output  CNT_W  SHALL count cycles in which OUT_VALID=1 and OUT_READY=0.

Function
REQ-015 The block SHALL define in_fire = IN_VALID & IN_READY and out_fire = OUT_VALID & OUT_READY.
REQ-016 The block SHALL hold two registers: MAIN, which drives OUT_DATA, and SKID, which is overflow storage.
REQ-017 The state machine SHALL have three states: EMPTY (occupancy 0), ONE (occupancy 1), FULL (occupancy 2).
REQ-018 In EMPTY, in_fire SHALL load MAIN<=IN_DATA and move to ONE; otherwise the state SHALL hold.
REQ-019 In ONE, transitions SHALL be:
- in_fire and out_fire: MAIN<=IN_DATA, stay in ONE.
- in_fire only: SKID<=IN_DATA, move to FULL.
- out_fire only: move to EMPTY.
- neither: hold.
REQ-020 In FULL, out_fire SHALL load MAIN<=SKID and move to ONE; otherwise the state SHALL hold.
REQ-021 IN_READY SHALL be 1 in EMPTY and ONE and 0 in FULL, and SHALL have no combinational path from OUT_READY, IN_VALID or FLUSH.
REQ-022 OUT_VALID SHALL be 1 exactly when the state is not EMPTY; OUT_DATA SHALL equal MAIN when OUT_VALID=1 and BUBBLE_DATA otherwise.
REQ-023 Latency: an entry accepted at edge N SHALL appear on OUT_DATA after edge N when the stage was EMPTY, or behind all older entries otherwise.
REQ-024 Entries SHALL leave in acceptance order, with no loss and no duplication.
REQ-025 While OUT_VALID=1 and OUT_READY=0, OUT_DATA SHALL remain stable.
REQ-026 FLUSH=1 at an edge SHALL set the state to EMPTY and set MAIN and SKID to BUBBLE_DATA.
REQ-027 FLUSH SHALL take priority over any simultaneous in_fire or out_fire; the incoming entry is dropped and IN_READY=1 that cycle does not imply acceptance.
REQ-028 STALL_CNT SHALL increment by 1 at each edge where OUT_VALID=1 and OUT_READY=0, and FLUSH does not clear it.
REQ-029 STALL_CNT SHALL saturate at 2^CNT_W-1.
REQ-030 OCCUPANCY SHALL equal 0, 1 or 2 for EMPTY, ONE or FULL respectively.

Reset
REQ-031 While RESET=1, the outputs SHALL be:
- state EMPTY, MAIN and SKID = BUBBLE_DATA;
- OUT_VALID=0, OUT_DATA=BUBBLE_DATA, IN_READY=1;
- OCCUPANCY=0, STALL_CNT=0.
REQ-032 While RESET=1, inputs SHALL be ignored.
REQ-033 RESET asserted mid-operation SHALL discard all held entries immediately, without waiting for a clock edge.
REQ-034 The first accepting edge SHALL be the first rising edge after RESET deasserts.

Verification
REQ-035 Streaming: OUT_READY=1, IN_VALID=1 with IN_DATA=1,2,3,4 on consecutive edges -> OUT_DATA=1,2,3,4 one cycle later; OCCUPANCY stays 1; STALL_CNT=0.
REQ-036 Backpressure:
- Stimulus: OUT_READY=0, IN_VALID=1 with IN_DATA=0xA then 0xB.
- Response: OCCUPANCY=2, IN_READY=0, OUT_DATA=0xA held.
- Release: OUT_READY=1 -> OUT_DATA=0xA then 0xB; STALL_CNT equals the stalled cycle count.
REQ-037 Flush: stage FULL, then FLUSH=1 with IN_VALID=1 and OUT_READY=1 -> next cycle OUT_VALID=0, OUT_DATA=BUBBLE_DATA, OCCUPANCY=0, IN_READY=1; no entry emitted or accepted.
REQ-038 Async reset: RESET pulsed between edges while FULL -> OUT_VALID=0 and STALL_CNT=0 immediately; the next entry 0x5 is accepted on the first edge after release.
REQ-039 Saturation: CNT_W=4 with OUT_VALID=1 and OUT_READY=0 held for 20 cycles -> STALL_CNT=15, not wrapped.
REQ-040 Random: random IN_VALID/OUT_READY/FLUSH over 10k cycles -> scoreboard confirms order, no loss outside flushes, and IN_READY=0 only in FULL.
